complex_accumulator: RTL and testbench

Integrate-and-dump stage that sits directly downstream of the complex multiplier. It sums a programmable number of consecutive valid complex products, component-wise, and emits one complex sum per frame with a one-cycle valid strobe. Typical uses are correlators and dot-product / matched-filter tails. Input and output use the shared `complex::logic_#(W)::p` packed type, with `re` and `im` fields, each signed two's complement.

---
 rtl/complex_accumulator.sv | 115 +++++++++++
 tb/tb_complex_accumulator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_accumulator.sv
// rtl/complex_accumulator.sv - integrate-and-dump complex accumulator; COMPLEX_ACC_SAT_EN selects saturating output
// Complex ports are packed {re, im}, with re in the upper half. This is the bit layout of complex::logic_#(W)::p.
module complex_accumulator #(
    parameter int IN_WIDTH  = 26,
    parameter int LEN_WIDTH = 8,
    parameter int OUT_WIDTH = 34
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LEN_WIDTH-1:0]   len_i,
    input  logic                   clear_i,
    input  logic [2*IN_WIDTH-1:0]  x_i,
    input  logic                   x_valid_i,
    output logic [2*OUT_WIDTH-1:0] y_o,
    output logic                   y_valid_o,
    output logic                   busy_o
);

    localparam int ACC_WIDTH = IN_WIDTH + LEN_WIDTH;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
    logic signed [ACC_WIDTH-1:0] x_re_ext, x_im_ext, sum_re, sum_im;
    logic [LEN_WIDTH-1:0]        cnt_q, cnt_d, len_q, len_d, len_eff;
    logic                        last, y_load;

`ifdef COMPLEX_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_ONE = 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (ACC_ONE <<< (OUT_WIDTH - 1)) - ACC_ONE;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

    function automatic logic [OUT_WIDTH-1:0] out_map(input logic signed [ACC_WIDTH-1:0] s);
`ifdef COMPLEX_ACC_SAT_EN
        if (s > SAT_MAX)
            return OUT_WIDTH'(SAT_MAX);
        else if (s < SAT_MIN)
            return OUT_WIDTH'(SAT_MIN);
        else
            return OUT_WIDTH'(s);
`else
        return OUT_WIDTH'(s);
`endif
    endfunction

    assign x_re_ext = {{LEN_WIDTH{x_i[2*IN_WIDTH-1]}}, x_i[2*IN_WIDTH-1:IN_WIDTH]};
    assign x_im_ext = {{LEN_WIDTH{x_i[IN_WIDTH-1]}}, x_i[IN_WIDTH-1:0]};
    // acc is zero in IDLE, so one adder serves both the first and later samples
    assign sum_re   = acc_re_q + x_re_ext;
    assign sum_im   = acc_im_q + x_im_ext;
    assign len_eff  = (len_i == '0) ? LEN_WIDTH'(1) : len_i;

    always_comb begin
        state_d  = state_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        last     = 1'b0;
        y_load   = 1'b0;
        if (clear_i) begin
            state_d  = IDLE;
            acc_re_d = '0;
            acc_im_d = '0;
            cnt_d    = '0;
        end else if (x_valid_i) begin
            case (state_q)
                IDLE: begin
                    len_d = len_eff;
                    last  = (len_eff == LEN_WIDTH'(1));
                end
                ACC:     last = ({1'b0, cnt_q} + 1'b1) == {1'b0, len_q};
                default: last = 1'b0;
            endcase
            if (last) begin
                y_load   = 1'b1;
                state_d  = IDLE;
                acc_re_d = '0;
                acc_im_d = '0;
                cnt_d    = '0;
            end else begin
                state_d  = ACC;
                acc_re_d = sum_re;
                acc_im_d = sum_im;
                cnt_d    = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            y_o       <= '0;
            y_valid_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            y_valid_o <= y_load;
            busy_o    <= (cnt_d != '0);
            if (y_load)
                y_o <= {out_map(sum_re), out_map(sum_im)};
        end
    end

endmodule

// File: tb/tb_complex_accumulator.sv
// tb/tb_complex_accumulator.sv - directed table, corner sequences and random model checks for complex_accumulator
module tb_complex_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  len_i;
    logic        clear_i;
    logic [51:0] x_i;
    logic        x_valid_i;
    logic [67:0] y_o;
    logic        y_valid_o, busy_o;
    logic [53:0] ys_o;
    logic        ys_valid_o, ys_busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    complex_accumulator #(.IN_WIDTH(26), .LEN_WIDTH(8), .OUT_WIDTH(34)) dut (
        .clk(clk), .rst_n(rst_n), .len_i(len_i), .clear_i(clear_i), .x_i(x_i),
        .x_valid_i(x_valid_i), .y_o(y_o), .y_valid_o(y_valid_o), .busy_o(busy_o));

    complex_accumulator #(.IN_WIDTH(26), .LEN_WIDTH(8), .OUT_WIDTH(27)) dut_s (
        .clk(clk), .rst_n(rst_n), .len_i(len_i), .clear_i(clear_i), .x_i(x_i),
        .x_valid_i(x_valid_i), .y_o(ys_o), .y_valid_o(ys_valid_o), .busy_o(ys_busy_o));

    typedef struct {
        bit     v;
        bit     clr;
        int     len;
        longint re;
        longint im;
        bit     ev;
        bit     eb;
        longint ere;
        longint eim;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add(input bit v, input bit c, input int l, input longint re, input longint im,
                       input bit ev, input bit eb, input longint ere, input longint eim);
        vec_t t;
        t.v = v; t.clr = c; t.len = l; t.re = re; t.im = im;
        t.ev = ev; t.eb = eb; t.ere = ere; t.eim = eim;
        vecs.push_back(t);
    endtask

    task automatic drive(input bit v, input bit c, input int l, input longint re, input longint im);
        logic [25:0] a, b;
        a = 26'(re);
        b = 26'(im);
        x_i       = {a, b};
        x_valid_i = v;
        clear_i   = c;
        len_i     = 8'(l);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint y_re();
        logic [33:0] t;
        t = y_o[67:34];
        return longint'($signed(t));
    endfunction

    function automatic longint y_im();
        logic [33:0] t;
        t = y_o[33:0];
        return longint'($signed(t));
    endfunction

    function automatic longint ys_re();
        logic [26:0] t;
        t = ys_o[53:27];
        return longint'($signed(t));
    endfunction

    function automatic longint ys_im();
        logic [26:0] t;
        t = ys_o[26:0];
        return longint'($signed(t));
    endfunction

    function automatic longint rnd26();
        logic [25:0] r;
        r = 26'($urandom);
        return longint'($signed(r));
    endfunction

    function automatic longint map27(input longint s);
        logic [26:0] t;
`ifdef COMPLEX_ACC_SAT_EN
        if (s > 64'sd67108863) return 64'sd67108863;
        if (s < -64'sd67108864) return -64'sd67108864;
        return s;
`else
        t = 27'(s);
        return longint'($signed(t));
`endif
    endfunction

    initial begin
        longint last_re, last_im, s_re, s_im, big;
        int     l, eff, strobes;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset_y_valid", y_valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_y_re", y_re(), 0);
        chk("reset_y_im", y_im(), 0);
        chk("reset_sat_y", ys_re(), 0);
        rst_n = 1'b1;

        // basic frame, len 4
        add(1, 0, 4, 1, -1, 0, 1, 0, 0);
        add(1, 0, 4, 2, -2, 0, 1, 0, 0);
        add(1, 0, 4, 3, -3, 0, 1, 0, 0);
        add(1, 0, 4, 4, -4, 1, 0, 10, -10);
        add(0, 0, 4, 0, 0, 0, 0, 0, 0);
        // gaps and length latch
        add(1, 0, 3, 5, 0, 0, 1, 0, 0);
        add(0, 0, 3, 9, 9, 0, 1, 0, 0);
        add(0, 0, 3, 9, 9, 0, 1, 0, 0);
        add(1, 0, 3, 5, 0, 0, 1, 0, 0);
        add(1, 0, 1, 5, 0, 1, 0, 15, 0);
        add(1, 0, 1, 7, 7, 1, 0, 7, 7);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // back-to-back, len 0 treated as 1
        for (int k = 1; k <= 6; k++)
            add(1, 0, 0, k, 0, 1, 0, k, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // abort with a valid sample in the clear cycle
        add(1, 0, 4, 9, 9, 0, 1, 0, 0);
        add(1, 0, 4, 9, 9, 0, 1, 0, 0);
        add(1, 1, 4, 100, 100, 0, 0, 0, 0);
        add(1, 0, 4, 1, 1, 0, 1, 0, 0);
        add(1, 0, 4, 1, 1, 0, 1, 0, 0);
        add(1, 0, 4, 1, 1, 0, 1, 0, 0);
        add(1, 0, 4, 1, 1, 1, 0, 4, 4);
        // clear on the frame's final sample drops its output
        add(1, 0, 2, 3, 3, 0, 1, 0, 0);
        add(1, 1, 2, 3, 3, 0, 0, 0, 0);
        add(0, 0, 2, 0, 0, 0, 0, 0, 0);

        last_re = 0;
        last_im = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].clr, vecs[i].len, vecs[i].re, vecs[i].im);
            tick();
            chk($sformatf("vec%0d_y_valid", i), y_valid_o, vecs[i].ev);
            chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].eb);
            if (vecs[i].ev) begin
                last_re = vecs[i].ere;
                last_im = vecs[i].eim;
            end
            chk($sformatf("vec%0d_y_re", i), y_re(), last_re);
            chk($sformatf("vec%0d_y_im", i), y_im(), last_im);
        end

        // reset mid-frame, then a full-length full-scale negative frame
        big = -(64'sd1 << 25);
        for (int k = 0; k < 100; k++) begin
            drive(1, 0, 255, big, big);
            tick();
        end
        chk("midframe_busy", busy_o, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_y_valid", y_valid_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_y_re", y_re(), 0);
        chk("rst_mid_y_im", y_im(), 0);
        strobes = 0;
        for (int k = 0; k < 254; k++) begin
            drive(1, 0, 255, big, big);
            tick();
            if (y_valid_o) strobes++;
        end
        chk("len255_early_strobes", strobes, 0);
        chk("len255_busy", busy_o, 1);
        drive(1, 0, 255, big, big);
        tick();
        chk("len255_y_valid", y_valid_o, 1);
        chk("len255_y_re", y_re(), -255 * (64'sd1 << 25));
        chk("len255_y_im", y_im(), -255 * (64'sd1 << 25));

        // saturation vs wrap on the 27-bit output instance
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 4, 64'sd33554431, 64'sd33554431);
            tick();
        end
        chk("sat_full_y_re", y_re(), 64'sd134217724);
        chk("sat_y_valid", ys_valid_o, 1);
`ifdef COMPLEX_ACC_SAT_EN
        chk("sat_y_re", ys_re(), 64'sd67108863);
        chk("sat_y_im", ys_im(), 64'sd67108863);
`else
        chk("wrap_y_re", ys_re(), -64'sd4);
        chk("wrap_y_im", ys_im(), -64'sd4);
`endif

        // random frames with gaps against an integer reference
        for (int f = 0; f < 300; f++) begin
            l   = int'($urandom_range(0, 5));
            eff = (l == 0) ? 1 : l;
            s_re = 0;
            s_im = 0;
            for (int i = 0; i < eff; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    drive(0, 0, int'($urandom_range(0, 255)), rnd26(), rnd26());
                    tick();
                    chk("rnd_gap_y_valid", y_valid_o, 0);
                end
                drive(1, 0, (i == 0) ? l : int'($urandom_range(0, 255)), rnd26(), rnd26());
                s_re += longint'($signed(x_i[51:26]));
                s_im += longint'($signed(x_i[25:0]));
                tick();
                chk("rnd_y_valid", y_valid_o, (i == eff - 1) ? 1 : 0);
            end
            chk("rnd_y_re", y_re(), s_re);
            chk("rnd_y_im", y_im(), s_im);
            chk("rnd_ys_re", ys_re(), map27(s_re));
            chk("rnd_ys_im", ys_im(), map27(s_im));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
